fault_mem_multi: RTL and testbench

Parametrised, runtime-configurable faulty SRAM model used as the device-under-test for the memory BIST controller. It replaces the fixed, single-fault, compile-time-address models with NUM_FAULTS independently programmable fault slots. Each slot supports stuck-at, transition and coupling faults. The block also counts fault activations so the bench can cross-check the BIST fail log against actual injections.

---
 rtl/fault_mem_pkg.sv | 43 ++++
 rtl/fault_mem_multi_slot.sv | 105 ++++++++++
 rtl/fault_mem_multi.sv | 157 +++++++++++++++
 tb/tb_fault_mem_multi.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fault_mem_pkg.sv
// Shared definitions for the multi-fault SRAM model.
// Holds the fault-type encoding, the per-slot configuration record and the
// load-validity check used by the top before a slot is written.
package fault_mem_pkg;

  localparam logic [2:0] FT_NONE  = 3'd0;
  localparam logic [2:0] FT_SA0   = 3'd1;
  localparam logic [2:0] FT_SA1   = 3'd2;
  localparam logic [2:0] FT_TF_UP = 3'd3;
  localparam logic [2:0] FT_TF_DN = 3'd4;
  localparam logic [2:0] FT_CFIN  = 3'd5;
  localparam logic [2:0] FT_CFID  = 3'd6;
  localparam logic [2:0] FT_RSVD  = 3'd7;

  // Fixed field widths so the record is independent of the memory geometry;
  // instances zero-extend their narrower address/bit fields into it.
  localparam int unsigned CFG_AW = 16;
  localparam int unsigned CFG_BW = 8;

  typedef struct packed {
    logic [2:0]        ftype;
    logic [CFG_AW-1:0] vaddr;
    logic [CFG_BW-1:0] vbit;
    logic [CFG_AW-1:0] aaddr;
    logic [CFG_BW-1:0] abit;
    logic              adir;
    logic              fval;
  } slot_cfg_t;

  function automatic logic is_cf(logic [2:0] t);
    return (t == FT_CFIN) || (t == FT_CFID);
  endfunction

  function automatic logic cfg_valid(slot_cfg_t c, int unsigned capacity);
    logic ok;
    ok = 1'b1;
    if (c.ftype == FT_RSVD) ok = 1'b0;
    if (32'(c.vaddr) >= capacity) ok = 1'b0;
    if (is_cf(c.ftype) && ((32'(c.aaddr) >= capacity) || (c.aaddr == c.vaddr))) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/fault_mem_multi_slot.sv
// One programmable fault slot.
// Holds the slot configuration and, for the access in flight, produces:
//   wmask/wval   bits of the addressed word overridden on store
//   rmask/rval   bits of the addressed word overridden on read
//   cf_*         coupling update of the victim word (victim_word is its current content)
// Ports: clk, rst, load, cfg_new, wr, rd, addr, wdata, old_word, victim_word,
//        vaddr, wmask, wval, rmask, rval, cf_en, cf_mask, cf_val, cf_hit.
module fault_slot import fault_mem_pkg::*; #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  slot_cfg_t             cfg_new,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] old_word,
  input  logic [DATA_WIDTH-1:0] victim_word,
  output logic [ADDR_WIDTH-1:0] vaddr,
  output logic [DATA_WIDTH-1:0] wmask,
  output logic [DATA_WIDTH-1:0] wval,
  output logic [DATA_WIDTH-1:0] rmask,
  output logic [DATA_WIDTH-1:0] rval,
  output logic                  cf_en,
  output logic [DATA_WIDTH-1:0] cf_mask,
  output logic [DATA_WIDTH-1:0] cf_val,
  output logic                  cf_hit
);

  slot_cfg_t cfg_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q <= '0;
    end else if (load) begin
      cfg_q <= cfg_new;
    end
  end

  logic [DATA_WIDTH-1:0] vmask, amask;
  logic v_sel, a_sel, v_new, v_old, a_new, a_old, vic_old, trig;

  assign vmask   = DATA_WIDTH'(1) << cfg_q.vbit;
  assign amask   = DATA_WIDTH'(1) << cfg_q.abit;
  assign v_sel   = (CFG_AW'(addr) == cfg_q.vaddr);
  assign a_sel   = (CFG_AW'(addr) == cfg_q.aaddr);
  assign v_new   = |(wdata & vmask);
  assign v_old   = |(old_word & vmask);
  assign a_new   = |(wdata & amask);
  assign a_old   = |(old_word & amask);
  assign vic_old = |(victim_word & vmask);
  assign trig    = cfg_q.adir ? (!a_old && a_new) : (a_old && !a_new);
  assign vaddr   = cfg_q.vaddr[ADDR_WIDTH-1:0];
  assign cf_mask = vmask;

  always_comb begin
    wmask  = '0;
    wval   = '0;
    rmask  = '0;
    rval   = '0;
    cf_en  = 1'b0;
    cf_val = '0;
    cf_hit = 1'b0;
    case (cfg_q.ftype)
      FT_SA0: begin
        if (wr && v_sel) wmask = vmask;
        if (rd && v_sel) rmask = vmask;
      end
      FT_SA1: begin
        if (wr && v_sel) wmask = vmask;
        if (rd && v_sel) rmask = vmask;
        wval = vmask;
        rval = vmask;
      end
      FT_TF_UP: begin
        if (wr && v_sel && !v_old && v_new) wmask = vmask;
      end
      FT_TF_DN: begin
        if (wr && v_sel && v_old && !v_new) begin
          wmask = vmask;
          wval  = vmask;
        end
      end
      FT_CFIN: begin
        if (wr && a_sel && trig) begin
          cf_en  = 1'b1;
          cf_val = vic_old ? '0 : vmask;
          cf_hit = 1'b1;
        end
      end
      FT_CFID: begin
        if (wr && a_sel && trig) begin
          cf_en  = 1'b1;
          cf_val = cfg_q.fval ? vmask : '0;
          cf_hit = (vic_old != cfg_q.fval);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fault_mem_multi.sv
// Faulty SRAM model with NUM_FAULTS runtime-programmable fault slots.
// Ports: clk, rst (sync, active-high), write_read (1 = write), address, wdata,
//        rdata (2-cycle read latency), cfg_load/cfg_slot/cfg_type/cfg_vaddr/cfg_vbit/
//        cfg_aaddr/cfg_abit/cfg_adir/cfg_fval (slot programming), cfg_err (rejected load),
//        fault_hits (saturating count of cycles where a fault changed a value).
// NUM_FAULTS must be at least 2; CAPACITY <= 2**ADDR_WIDTH.
module fault_mem_multi import fault_mem_pkg::*; #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 6,
  parameter int unsigned CAPACITY    = 64,
  parameter int unsigned NUM_FAULTS  = 4,
  parameter int unsigned WDATA_DELAY = 1,
  parameter int unsigned HIT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          write_read,
  input  logic [ADDR_WIDTH-1:0]         address,
  input  logic [DATA_WIDTH-1:0]         wdata,
  output logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          cfg_load,
  input  logic [$clog2(NUM_FAULTS)-1:0] cfg_slot,
  input  logic [2:0]                    cfg_type,
  input  logic [ADDR_WIDTH-1:0]         cfg_vaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_vbit,
  input  logic [ADDR_WIDTH-1:0]         cfg_aaddr,
  input  logic [$clog2(DATA_WIDTH)-1:0] cfg_abit,
  input  logic                          cfg_adir,
  input  logic                          cfg_fval,
  output logic                          cfg_err,
  output logic [HIT_WIDTH-1:0]          fault_hits
);

  localparam int unsigned SLOT_W = $clog2(NUM_FAULTS);
  localparam logic [ADDR_WIDTH:0] CAP = (ADDR_WIDTH+1)'(CAPACITY);

  logic [DATA_WIDTH-1:0] mem [CAPACITY];
  logic [DATA_WIDTH-1:0] stage1, wd_q, wd_eff, mem_word, store_word, read_word;
  logic in_range, wr_ok, rd_ok, any_hit;

  slot_cfg_t cfg_new;
  logic      cfg_ok;

  always_comb begin
    cfg_new       = '0;
    cfg_new.ftype = cfg_type;
    cfg_new.vaddr = CFG_AW'(cfg_vaddr);
    cfg_new.vbit  = CFG_BW'(cfg_vbit);
    cfg_new.aaddr = CFG_AW'(cfg_aaddr);
    cfg_new.abit  = CFG_BW'(cfg_abit);
    cfg_new.adir  = cfg_adir;
    cfg_new.fval  = cfg_fval;
  end

  assign cfg_ok   = cfg_valid(cfg_new, CAPACITY);
  assign in_range = ({1'b0, address} < CAP);
  assign wr_ok    = !rst && write_read && in_range;
  assign rd_ok    = !rst && !write_read && in_range;
  assign wd_eff   = (WDATA_DELAY != 0) ? wd_q : wdata;
  assign mem_word = mem[address];

  logic [DATA_WIDTH-1:0] wmask [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] wval  [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] rmask [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] rval  [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] cf_mask [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] cf_val  [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] vic_word [NUM_FAULTS];
  logic [DATA_WIDTH-1:0] vic_new  [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] vaddr [NUM_FAULTS];
  logic [NUM_FAULTS-1:0] cf_en, cf_hit, load;

  for (genvar i = 0; i < NUM_FAULTS; i++) begin : g_slot
    assign load[i]     = cfg_load && cfg_ok && (cfg_slot == SLOT_W'(i));
    assign vic_word[i] = mem[vaddr[i]];

    fault_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (load[i]),
      .cfg_new    (cfg_new),
      .wr         (wr_ok),
      .rd         (rd_ok),
      .addr       (address),
      .wdata      (wd_eff),
      .old_word   (mem_word),
      .victim_word(vic_word[i]),
      .vaddr      (vaddr[i]),
      .wmask      (wmask[i]),
      .wval       (wval[i]),
      .rmask      (rmask[i]),
      .rval       (rval[i]),
      .cf_en      (cf_en[i]),
      .cf_mask    (cf_mask[i]),
      .cf_val     (cf_val[i]),
      .cf_hit     (cf_hit[i])
    );
  end

  // Merge in ascending slot order so a higher slot wins on a shared bit.
  always_comb begin
    store_word = wd_eff;
    read_word  = in_range ? mem_word : '0;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      store_word = (store_word & ~wmask[i]) | (wval[i] & wmask[i]);
      read_word  = (read_word & ~rmask[i]) | (rval[i] & rmask[i]);
    end
  end

  // Each victim word accumulates every lower-or-equal slot hitting the same word, so the
  // last writer of that word in the memory loop carries all coupling effects.
  always_comb begin
    for (int i = 0; i < NUM_FAULTS; i++) begin
      vic_new[i] = vic_word[i];
      for (int j = 0; j <= i; j++) begin
        if (cf_en[j] && (vaddr[j] == vaddr[i])) begin
          vic_new[i] = (vic_new[i] & ~cf_mask[j]) | (cf_val[j] & cf_mask[j]);
        end
      end
    end
  end

  assign any_hit = (wr_ok && (store_word != wd_eff)) ||
                   (rd_ok && (read_word != mem_word)) || (|cf_hit);

  // Array contents deliberately survive reset; wr_ok already excludes the reset cycle.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[address] <= store_word;
      for (int i = 0; i < NUM_FAULTS; i++) begin
        if (cf_en[i]) mem[vaddr[i]] <= vic_new[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage1     <= '0;
      rdata      <= '0;
      wd_q       <= '0;
      cfg_err    <= 1'b0;
      fault_hits <= '0;
    end else begin
      wd_q    <= wdata;
      rdata   <= stage1;
      cfg_err <= cfg_load && !cfg_ok;
      if (!write_read) stage1 <= read_word;
      if (any_hit && (fault_hits != {HIT_WIDTH{1'b1}})) begin
        fault_hits <= fault_hits + HIT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fault_mem_multi.sv
// Directed self-checking bench for fault_mem_multi (CAPACITY 48 so that
// out-of-range addresses exist, HIT_WIDTH 3 so saturation is reachable).
module tb_fault_mem_multi;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
  localparam int unsigned NF = 4;
  localparam int unsigned HW = 3;
  localparam logic [AW-1:0] IDLE = 6'd63;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_read = 1'b0;
  logic [AW-1:0] address = IDLE;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] rdata;
  logic          cfg_load = 1'b0;
  logic [1:0]    cfg_slot = '0;
  logic [2:0]    cfg_type = '0;
  logic [AW-1:0] cfg_vaddr = '0;
  logic [2:0]    cfg_vbit = '0;
  logic [AW-1:0] cfg_aaddr = '0;
  logic [2:0]    cfg_abit = '0;
  logic          cfg_adir = 1'b0;
  logic          cfg_fval = 1'b0;
  logic          cfg_err;
  logic [HW-1:0] fault_hits;

  int total = 0;
  int bad = 0;

  fault_mem_multi #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .CAPACITY   (48),
    .NUM_FAULTS (NF),
    .WDATA_DELAY(1),
    .HIT_WIDTH  (HW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .write_read(write_read),
    .address   (address),
    .wdata     (wdata),
    .rdata     (rdata),
    .cfg_load  (cfg_load),
    .cfg_slot  (cfg_slot),
    .cfg_type  (cfg_type),
    .cfg_vaddr (cfg_vaddr),
    .cfg_vbit  (cfg_vbit),
    .cfg_aaddr (cfg_aaddr),
    .cfg_abit  (cfg_abit),
    .cfg_adir  (cfg_adir),
    .cfg_fval  (cfg_fval),
    .cfg_err   (cfg_err),
    .fault_hits(fault_hits)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Write data is pipelined by one cycle, so it is presented one cycle ahead.
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wdata = d;
    write_read = 1'b0;
    address = IDLE;
    tick();
    write_read = 1'b1;
    address = a;
    tick();
    write_read = 1'b0;
    address = IDLE;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    write_read = 1'b0;
    address = a;
    tick();
    address = IDLE;
    tick();
    d = rdata;
  endtask

  task automatic do_load(input logic [1:0] s, input logic [2:0] t, input logic [AW-1:0] va,
                         input logic [2:0] vb, input logic [AW-1:0] aa, input logic [2:0] ab,
                         input logic dir, input logic fv);
    cfg_slot = s; cfg_type = t; cfg_vaddr = va; cfg_vbit = vb;
    cfg_aaddr = aa; cfg_abit = ab; cfg_adir = dir; cfg_fval = fv;
    cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL reset_rdata got=%h exp=00", rdata); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_cfg_err got=%b exp=0", cfg_err); end
    total++; if (fault_hits !== 3'd0) begin bad++; $display("FAIL reset_hits got=%0d exp=0", fault_hits); end
  endtask

  task automatic test_no_fault();
    logic [DW-1:0] got;
    do_reset();
    do_write(6'd3, 8'hA5);
    write_read = 1'b0;
    address = 6'd3;
    tick();
    total++; if (rdata !== 8'h00) begin bad++; $display("FAIL latency_early got=%h exp=00", rdata); end
    address = IDLE;
    tick();
    total++; if (rdata !== 8'hA5) begin bad++; $display("FAIL nofault_read got=%h exp=a5", rdata); end
    do_write(6'd50, 8'h77);
    do_read(6'd50, got);
    total++; if (got !== 8'h00) begin bad++; $display("FAIL oor_read got=%h exp=00", got); end
    do_read(6'd3, got);
    total++; if (got !== 8'hA5) begin bad++; $display("FAIL nofault_reread got=%h exp=a5", got); end
    total++; if (fault_hits !== 3'd0) begin bad++; $display("FAIL nofault_hits got=%0d exp=0", fault_hits); end
  endtask

  task automatic test_sa1();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd0, 3'd2, 6'd5, 3'd0, 6'd0, 3'd0, 1'b0, 1'b0);
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL sa1_cfg_err got=%b exp=0", cfg_err); end
    do_write(6'd5, 8'h00);
    do_read(6'd5, got);
    total++; if (got !== 8'h01) begin bad++; $display("FAIL sa1_read got=%h exp=01", got); end
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL sa1_hits got=%0d exp=1", fault_hits); end
    do_write(6'd5, 8'h03);
    do_read(6'd5, got);
    total++; if (got !== 8'h03) begin bad++; $display("FAIL sa1_match_read got=%h exp=03", got); end
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL sa1_nohit got=%0d exp=1", fault_hits); end
  endtask

  task automatic test_tf_dn();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd1, 3'd4, 6'd10, 3'd1, 6'd0, 3'd0, 1'b0, 1'b0);
    do_write(6'd10, 8'hFF);
    do_write(6'd10, 8'h00);
    do_read(6'd10, got);
    total++; if (got !== 8'h02) begin bad++; $display("FAIL tfdn_read got=%h exp=02", got); end
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL tfdn_hits got=%0d exp=1", fault_hits); end
  endtask

  task automatic test_cfid();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd2, 3'd6, 6'd9, 3'd3, 6'd8, 3'd7, 1'b0, 1'b1);
    do_write(6'd9, 8'h00);
    do_write(6'd8, 8'h80);
    do_write(6'd8, 8'h00);
    do_read(6'd9, got);
    total++; if (got !== 8'h08) begin bad++; $display("FAIL cfid_victim got=%h exp=08", got); end
    do_read(6'd8, got);
    total++; if (got !== 8'h00) begin bad++; $display("FAIL cfid_aggr got=%h exp=00", got); end
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL cfid_hits got=%0d exp=1", fault_hits); end
  endtask

  task automatic test_cfin();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd3, 3'd5, 6'd31, 3'd7, 6'd30, 3'd0, 1'b1, 1'b0);
    do_write(6'd31, 8'h0F);
    do_write(6'd30, 8'h00);
    do_write(6'd30, 8'h01);
    do_read(6'd31, got);
    total++; if (got !== 8'h8F) begin bad++; $display("FAIL cfin_victim got=%h exp=8f", got); end
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL cfin_hits got=%0d exp=1", fault_hits); end
  endtask

  task automatic test_override();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd0, 3'd1, 6'd20, 3'd2, 6'd0, 3'd0, 1'b0, 1'b0);
    do_load(2'd1, 3'd2, 6'd20, 3'd2, 6'd0, 3'd0, 1'b0, 1'b0);
    do_write(6'd20, 8'h00);
    do_read(6'd20, got);
    total++; if (got !== 8'h04) begin bad++; $display("FAIL override_read got=%h exp=04", got); end
    do_write(6'd20, 8'h04);
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL override_hits got=%0d exp=1", fault_hits); end
  endtask

  task automatic test_reject();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd0, 3'd7, 6'd4, 3'd0, 6'd0, 3'd0, 1'b0, 1'b0);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL rej_type7 got=%b exp=1", cfg_err); end
    tick();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL rej_pulse got=%b exp=0", cfg_err); end
    do_load(2'd0, 3'd5, 6'd4, 3'd1, 6'd4, 3'd2, 1'b1, 1'b0);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL rej_same_addr got=%b exp=1", cfg_err); end
    do_load(2'd1, 3'd2, 6'd50, 3'd0, 6'd0, 3'd0, 1'b0, 1'b0);
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL rej_oor got=%b exp=1", cfg_err); end
    do_write(6'd4, 8'h5A);
    do_read(6'd4, got);
    total++; if (got !== 8'h5A) begin bad++; $display("FAIL rej_read got=%h exp=5a", got); end
    total++; if (fault_hits !== 3'd0) begin bad++; $display("FAIL rej_hits got=%0d exp=0", fault_hits); end
  endtask

  task automatic test_rst_mid();
    logic [DW-1:0] got;
    do_reset();
    do_load(2'd0, 3'd1, 6'd2, 3'd0, 6'd0, 3'd0, 1'b0, 1'b0);
    do_write(6'd2, 8'h01);
    total++; if (fault_hits !== 3'd1) begin bad++; $display("FAIL sa0_hits got=%0d exp=1", fault_hits); end
    wdata = 8'hFF;
    write_read = 1'b1;
    address = 6'd2;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    write_read = 1'b0;
    address = IDLE;
    total++; if (fault_hits !== 3'd0) begin bad++; $display("FAIL rst_hits got=%0d exp=0", fault_hits); end
    do_read(6'd2, got);
    total++; if (got !== 8'h00) begin bad++; $display("FAIL rst_ignored_write got=%h exp=00", got); end
    do_write(6'd2, 8'h01);
    do_read(6'd2, got);
    total++; if (got !== 8'h01) begin bad++; $display("FAIL rst_slot_cleared got=%h exp=01", got); end
    total++; if (fault_hits !== 3'd0) begin bad++; $display("FAIL rst_after_hits got=%0d exp=0", fault_hits); end
  endtask

  task automatic test_saturate();
    do_reset();
    do_load(2'd0, 3'd2, 6'd40, 3'd0, 6'd0, 3'd0, 1'b0, 1'b0);
    for (int i = 0; i < 7; i++) do_write(6'd40, 8'h00);
    total++; if (fault_hits !== 3'd7) begin bad++; $display("FAIL sat_reach got=%0d exp=7", fault_hits); end
    do_write(6'd40, 8'h00);
    do_write(6'd40, 8'h00);
    total++; if (fault_hits !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", fault_hits); end
  endtask

  initial begin
    test_reset();
    test_no_fault();
    test_sa1();
    test_tf_dn();
    test_cfid();
    test_cfin();
    test_override();
    test_reject();
    test_rst_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
